// File: rtl/readout_ddr_writer.sv
// rtl/readout_ddr_writer.sv - drains 256-bit readout FIFO words into a ring of DDR3 frame slots
// through the MIG native write interface and reports each completed frame.
module readout_ddr_writer #(
   parameter int  ADDR_W          = 28,
   parameter int  BASE_ADDR       = 0,
   parameter int  ADDR_STEP       = 8,
   parameter int  WORDS_PER_FRAME = 656,
   parameter int  NUM_FRAMES      = 4,
   localparam int FI_W            = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
   input  logic              sys_clk,
   input  logic              delay_nrst,
   input  logic              enable,
   input  logic              data_avail,
   output logic              data_rd_en,
   input  logic [255:0]      data_out,
   output logic              app_en,
   output logic [2:0]        app_cmd,
   output logic [ADDR_W-1:0] app_addr,
   input  logic              app_rdy,
   output logic              app_wdf_wren,
   output logic              app_wdf_end,
   output logic [255:0]      app_wdf_data,
   output logic [31:0]       app_wdf_mask,
   input  logic              app_wdf_rdy,
   output logic              frame_done,
   output logic [FI_W-1:0]   frame_idx,
   output logic [15:0]       frames_written,
   output logic              busy
);

   localparam int                WC_W      = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
   localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(WORDS_PER_FRAME - 1);
   localparam logic [FI_W-1:0]   LAST_SLOT = FI_W'(NUM_FRAMES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_LATCH,
      S_WRITE,
      S_ADV
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] word_addr_q;
   logic [WC_W-1:0]   word_cnt_q;
   logic [FI_W-1:0]   cur_slot_q;
   logic [FI_W-1:0]   frame_idx_q;
   logic [15:0]       frames_written_q;
   logic [255:0]      wbuf_q;
   logic              cmd_done_q;
   logic              dat_done_q;
   logic              app_en_q;
   logic              wren_q;
   logic              frame_done_q;
   logic              cmd_done_d;
   logic              dat_done_d;

   // Acceptance seen this cycle counts immediately, so WRITE leaves on the accepting edge.
   always_comb begin
      cmd_done_d = cmd_done_q | (app_en_q & app_rdy);
      dat_done_d = dat_done_q | (wren_q & app_wdf_rdy);
   end

   always_ff @(posedge sys_clk or negedge delay_nrst) begin
      if (!delay_nrst) begin
         state_q          <= S_IDLE;
         word_addr_q      <= BASE;
         word_cnt_q       <= '0;
         cur_slot_q       <= '0;
         frame_idx_q      <= '0;
         frames_written_q <= '0;
         wbuf_q           <= '0;
         cmd_done_q       <= 1'b0;
         dat_done_q       <= 1'b0;
         app_en_q         <= 1'b0;
         wren_q           <= 1'b0;
         frame_done_q     <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (enable && data_avail) begin
                  state_q <= S_RD;
               end
            end
            S_RD: begin
               state_q <= S_LATCH;
            end
            S_LATCH: begin
               wbuf_q     <= data_out;
               cmd_done_q <= 1'b0;
               dat_done_q <= 1'b0;
               app_en_q   <= 1'b1;
               wren_q     <= 1'b1;
               state_q    <= S_WRITE;
            end
            S_WRITE: begin
               cmd_done_q <= cmd_done_d;
               dat_done_q <= dat_done_d;
               app_en_q   <= ~cmd_done_d;
               wren_q     <= ~dat_done_d;
               if (cmd_done_d && dat_done_d) begin
                  state_q <= S_ADV;
                  // Frame report lands on the same edge that raises frame_done.
                  if (word_cnt_q == LAST_WORD) begin
                     frame_done_q     <= 1'b1;
                     frame_idx_q      <= cur_slot_q;
                     frames_written_q <= frames_written_q + 16'd1;
                  end
               end
            end
            S_ADV: begin
               state_q <= S_IDLE;
               if (word_cnt_q == LAST_WORD) begin
                  word_cnt_q <= '0;
                  if (cur_slot_q == LAST_SLOT) begin
                     cur_slot_q  <= '0;
                     word_addr_q <= BASE;
                  end else begin
                     cur_slot_q  <= cur_slot_q + FI_W'(1);
                     word_addr_q <= word_addr_q + STEP;
                  end
               end else begin
                  word_cnt_q  <= word_cnt_q + WC_W'(1);
                  word_addr_q <= word_addr_q + STEP;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // The read strobe is issued in the IDLE cycle itself so FIFO data is ready by LATCH.
   assign data_rd_en     = delay_nrst & (state_q == S_IDLE) & enable & data_avail;
   assign app_en         = app_en_q;
   assign app_cmd        = 3'b000;
   assign app_addr       = word_addr_q;
   assign app_wdf_wren   = wren_q;
   assign app_wdf_end    = wren_q;
   assign app_wdf_data   = wbuf_q;
   assign app_wdf_mask   = 32'h0;
   assign frame_done     = frame_done_q;
   assign frame_idx      = frame_idx_q;
   assign frames_written = frames_written_q;
   assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_readout_ddr_writer.sv
// tb/tb_readout_ddr_writer.sv - self-checking bench for readout_ddr_writer with a FIFO model,
// a word/frame-level reference model and directed scenarios.
module tb_readout_ddr_writer;

   localparam int ADDR_W = 28;
   localparam int BASE   = 0;
   localparam int STEP   = 8;
   localparam int WPF    = 4;
   localparam int NF     = 2;

   logic              sys_clk    = 1'b0;
   logic              delay_nrst = 1'b0;
   logic              enable     = 1'b0;
   logic              data_avail;
   logic              data_rd_en;
   logic [255:0]      data_out   = '0;
   logic              app_en;
   logic [2:0]        app_cmd;
   logic [ADDR_W-1:0] app_addr;
   logic              app_rdy     = 1'b0;
   logic              app_wdf_wren;
   logic              app_wdf_end;
   logic [255:0]      app_wdf_data;
   logic [31:0]       app_wdf_mask;
   logic              app_wdf_rdy = 1'b0;
   logic              frame_done;
   logic [0:0]        frame_idx;
   logic [15:0]       frames_written;
   logic              busy;

   readout_ddr_writer #(
      .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .ADDR_STEP(STEP),
      .WORDS_PER_FRAME(WPF), .NUM_FRAMES(NF)
   ) dut (
      .sys_clk(sys_clk), .delay_nrst(delay_nrst), .enable(enable),
      .data_avail(data_avail), .data_rd_en(data_rd_en), .data_out(data_out),
      .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
      .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
      .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
      .frame_done(frame_done), .frame_idx(frame_idx), .frames_written(frames_written),
      .busy(busy)
   );

   always #5 sys_clk = ~sys_clk;

   // Readout FIFO: first-word-fall-through is not used; data appears the cycle after the strobe.
   logic [255:0] src_mem [0:63];
   int src_wr = 0;
   int src_rd = 0;
   assign data_avail = (src_wr != src_rd);

   always @(posedge sys_clk) begin
      if (data_rd_en && (src_rd != src_wr)) begin
         data_out <= src_mem[src_rd];
         src_rd   <= src_rd + 1;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   int           cyc = 0;
   int           done_n = 0;
   logic         cmd_acc = 1'b0;
   logic         dat_acc = 1'b0;
   logic         in_flight = 1'b0;
   logic         fd_due = 1'b0;
   logic [15:0]  exp_frames = '0;
   int           exp_idx = 0;
   logic         prev_act = 1'b0;
   logic [ADDR_W-1:0] prev_addr = '0;
   logic [255:0] prev_data = '0;
   int           en_cycles = 0;
   int           wren_cycles = 0;
   logic [255:0] exp_data_q [$];
   int           rd_log [$];
   logic [ADDR_W-1:0] wr_addr_log [$];
   logic [255:0] wr_data_log [$];
   int           fd_idx_log [$];
   logic [15:0]  fd_cnt_log [$];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic reset_model();
      done_n = 0; cmd_acc = 1'b0; dat_acc = 1'b0; in_flight = 1'b0;
      fd_due = 1'b0; exp_frames = '0; exp_idx = 0; prev_act = 1'b0;
      exp_data_q.delete();
   endtask

   task automatic clear_logs();
      rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
      fd_idx_log.delete(); fd_cnt_log.delete();
      en_cycles = 0; wren_cycles = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rd_en"}, 256'(data_rd_en), 256'(0));
      chk({tag, "_app_en"}, 256'(app_en), 256'(0));
      chk({tag, "_wren"}, 256'(app_wdf_wren), 256'(0));
      chk({tag, "_addr"}, 256'(app_addr), 256'(BASE));
      chk({tag, "_wdata"}, app_wdf_data, 256'(0));
      chk({tag, "_fdone"}, 256'(frame_done), 256'(0));
      chk({tag, "_fidx"}, 256'(frame_idx), 256'(0));
      chk({tag, "_fcnt"}, 256'(frames_written), 256'(0));
      chk({tag, "_busy"}, 256'(busy), 256'(0));
   endtask

   // Word/frame-level reference: the k-th word since reset goes to BASE + (k mod ring)*STEP.
   task automatic monitor();
      logic [ADDR_W-1:0] ea;
      logic act;
      cyc++;
      if (!delay_nrst) begin
         check_reset_outputs("rst");
         reset_model();
         return;
      end
      chk("app_cmd", 256'(app_cmd), 256'(0));
      chk("wdf_mask", 256'(app_wdf_mask), 256'(0));
      chk("wdf_end", 256'(app_wdf_end), 256'(app_wdf_wren));
      if (data_rd_en) begin
         chk("rd_underflow", 256'(data_avail), 256'(1));
         chk("rd_in_flight", 256'(in_flight), 256'(0));
         if (data_avail) exp_data_q.push_back(src_mem[src_rd]);
         in_flight = 1'b1;
         rd_log.push_back(cyc);
      end
      act = app_en | app_wdf_wren;
      if (act && prev_act) begin
         chk("addr_stable", 256'(app_addr), 256'(prev_addr));
         chk("data_stable", app_wdf_data, prev_data);
      end
      chk("frame_done", 256'(frame_done), 256'(fd_due));
      chk("frames_written", 256'(frames_written), 256'(exp_frames));
      chk("frame_idx", 256'(frame_idx), 256'(exp_idx));
      if (frame_done) begin
         fd_idx_log.push_back(int'(frame_idx));
         fd_cnt_log.push_back(frames_written);
      end
      fd_due = 1'b0;
      ea = ADDR_W'(BASE + (done_n % (WPF * NF)) * STEP);
      if (act) chk("strobe_in_flight", 256'(in_flight), 256'(1));
      if (app_en) begin
         chk("cmd_once", 256'(cmd_acc), 256'(0));
         chk("app_addr", 256'(app_addr), 256'(ea));
         en_cycles++;
      end
      if (app_wdf_wren) begin
         chk("wdf_once", 256'(dat_acc), 256'(0));
         chk("wdf_pending", 256'(exp_data_q.size()), 256'(1));
         if (exp_data_q.size() > 0) chk("wdf_data", app_wdf_data, exp_data_q[0]);
         wren_cycles++;
      end
      if (app_en && app_rdy) cmd_acc = 1'b1;
      if (app_wdf_wren && app_wdf_rdy) dat_acc = 1'b1;
      if (cmd_acc && dat_acc) begin
         wr_addr_log.push_back(app_addr);
         wr_data_log.push_back(app_wdf_data);
         if (exp_data_q.size() > 0) void'(exp_data_q.pop_front());
         done_n++;
         cmd_acc = 1'b0; dat_acc = 1'b0; in_flight = 1'b0;
         if (done_n % WPF == 0) begin
            fd_due     = 1'b1;
            exp_frames = exp_frames + 16'd1;
            exp_idx    = (done_n / WPF - 1) % NF;
         end
         act = 1'b0;
      end
      prev_act  = act;
      prev_addr = app_addr;
      prev_data = app_wdf_data;
   endtask

   task automatic tick();
      @(negedge sys_clk);
      monitor();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic push(input logic [255:0] w);
      src_mem[src_wr] = w;
      src_wr++;
   endtask

   task automatic apply_reset();
      delay_nrst = 1'b0;
      repeat (3) tick();
      delay_nrst = 1'b1;
      tick();
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int k = 0;
      while (done_n < target && k < budget) begin
         tick();
         k++;
      end
      chk(name, 256'(done_n >= target), 256'(1));
   endtask

   task automatic wait_en(input int want_done, input int budget, input string name);
      int k = 0;
      while (!(app_en && done_n == want_done) && k < budget) begin
         tick();
         k++;
      end
      chk(name, 256'(app_en && done_n == want_done), 256'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      apply_reset();
      check_reset_outputs("after_reset");

      // Stream: three words, no back-pressure.
      clear_logs();
      app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      push(256'd1); push(256'd2); push(256'd3);
      enable = 1'b1;
      wait_done(3, 100, "stream_timeout");
      repeat (3) tick();
      chk("stream_rd_count", 256'(rd_log.size()), 256'(3));
      if (rd_log.size() == 3) begin
         chk("stream_spacing0", 256'(rd_log[1] - rd_log[0]), 256'(5));
         chk("stream_spacing1", 256'(rd_log[2] - rd_log[1]), 256'(5));
      end
      chk("stream_wr_count", 256'(wr_addr_log.size()), 256'(3));
      if (wr_addr_log.size() == 3) begin
         chk("stream_addr0", 256'(wr_addr_log[0]), 256'(0));
         chk("stream_addr1", 256'(wr_addr_log[1]), 256'(8));
         chk("stream_addr2", 256'(wr_addr_log[2]), 256'(16));
         chk("stream_data0", wr_data_log[0], 256'd1);
         chk("stream_data2", wr_data_log[2], 256'd3);
      end
      chk("stream_no_frame", 256'(fd_idx_log.size()), 256'(0));
      chk("stream_idle", 256'(busy), 256'(0));
      enable = 1'b0;

      // Command channel held off for 4 cycles while data is accepted at once.
      apply_reset();
      clear_logs();
      app_rdy = 1'b0; app_wdf_rdy = 1'b1;
      push(256'hA5A5);
      enable = 1'b1;
      wait_en(0, 50, "bp_wait_en");
      repeat (4) tick();
      app_rdy = 1'b1;
      wait_done(1, 50, "bp_timeout");
      repeat (2) tick();
      chk("bp_en_cycles", 256'(en_cycles), 256'(5));
      chk("bp_wren_cycles", 256'(wren_cycles), 256'(1));
      chk("bp_wr_count", 256'(wr_addr_log.size()), 256'(1));
      if (wr_addr_log.size() == 1) begin
         chk("bp_addr", 256'(wr_addr_log[0]), 256'(0));
         chk("bp_data", wr_data_log[0], 256'hA5A5);
      end
      enable = 1'b0;

      // Ring wrap: two 4-word frames then a ninth word back at the base.
      apply_reset();
      clear_logs();
      app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      for (int i = 0; i < 9; i++) push(256'(32'h100 + i));
      enable = 1'b1;
      wait_done(9, 200, "ring_timeout");
      repeat (3) tick();
      chk("ring_fd_count", 256'(fd_idx_log.size()), 256'(2));
      if (fd_idx_log.size() == 2) begin
         chk("ring_fd_idx0", 256'(fd_idx_log[0]), 256'(0));
         chk("ring_fd_idx1", 256'(fd_idx_log[1]), 256'(1));
         chk("ring_fd_cnt0", 256'(fd_cnt_log[0]), 256'(1));
         chk("ring_fd_cnt1", 256'(fd_cnt_log[1]), 256'(2));
      end
      chk("ring_frames", 256'(frames_written), 256'(2));
      if (wr_addr_log.size() == 9) begin
         chk("ring_addr4", 256'(wr_addr_log[4]), 256'(32));
         chk("ring_addr8", 256'(wr_addr_log[8]), 256'(BASE));
         chk("ring_data8", wr_data_log[8], 256'h108);
      end else begin
         chk("ring_wr_count", 256'(wr_addr_log.size()), 256'(9));
      end
      enable = 1'b0;

      // Enable dropped while word 2 is in WRITE.
      apply_reset();
      clear_logs();
      app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      push(256'h201); push(256'h202); push(256'h203);
      enable = 1'b1;
      wait_en(1, 50, "endrop_wait_en");
      enable = 1'b0;
      wait_done(2, 50, "endrop_timeout");
      repeat (20) tick();
      chk("endrop_rd_count", 256'(rd_log.size()), 256'(2));
      chk("endrop_halted", 256'(busy), 256'(0));
      chk("endrop_no_rd", 256'(data_rd_en), 256'(0));
      enable = 1'b1;
      wait_done(3, 50, "endrop_resume_timeout");
      repeat (3) tick();
      if (wr_addr_log.size() == 3) begin
         chk("endrop_addr2", 256'(wr_addr_log[2]), 256'(16));
         chk("endrop_data2", wr_data_log[2], 256'h203);
      end else begin
         chk("endrop_wr_count", 256'(wr_addr_log.size()), 256'(3));
      end
      enable = 1'b0;

      // Asynchronous reset while word 5 is stalled in WRITE.
      apply_reset();
      clear_logs();
      app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      for (int i = 1; i <= 6; i++) push(256'(32'h300 + i));
      enable = 1'b1;
      wait_done(4, 100, "rst_frame_timeout");
      app_rdy = 1'b0; app_wdf_rdy = 1'b0;
      wait_en(4, 50, "rst_wait_en");
      repeat (2) tick();
      chk("pre_rst_frames", 256'(frames_written), 256'(1));
      #2;
      delay_nrst = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      repeat (2) tick();
      delay_nrst = 1'b1;
      clear_logs();
      app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      wait_done(1, 50, "post_rst_timeout");
      repeat (3) tick();
      if (wr_addr_log.size() >= 1) begin
         chk("post_rst_addr", 256'(wr_addr_log[0]), 256'(BASE));
         chk("post_rst_data", wr_data_log[0], 256'h306);
      end else begin
         chk("post_rst_wr_count", 256'(wr_addr_log.size()), 256'(1));
      end
      chk("post_rst_frames", 256'(frames_written), 256'(0));
      enable = 1'b0;
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
